// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_controller
// Purpose  : Moore FSM for a highway / country-road intersection. The highway
//            holds green until the side-road sensor x requests right-of-way,
//            then the light sequences highway yellow, all-red, road green and
//            road yellow before returning to highway green.
// Revision : 1.0 - initial release
//
// Ports    : clock  in   system clock, all state changes on the rising edge
//            clear  in   asynchronous active-high reset
//            x      in   side-road car sensor (1 = car waiting/present)
//            hwy    out  highway lamp  2'b00 RED, 2'b01 GREEN, 2'b10 YELLOW
//            road   out  road lamp, same encoding as hwy
//
// Params   : Y2R_DELAY      cycles in each yellow state (1..15)
//            R2G_DELAY      cycles in ALL_RED (1..15)
//            ROAD_MAX_GREEN road-green limit, timeout build only (1..255)
//
// Option   : define TLC_ROAD_TIMEOUT_EN to force ROAD_YELLOW after
//            ROAD_MAX_GREEN cycles of road green even while x stays 1.
// ============================================================================
module traffic_light_controller #(
    parameter int Y2R_DELAY      = 3,
    parameter int R2G_DELAY      = 2,
    parameter int ROAD_MAX_GREEN = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       x,
    output logic [1:0] hwy,
    output logic [1:0] road
);

    typedef enum logic [2:0] {
        HWY_GREEN   = 3'd0,
        HWY_YELLOW  = 3'd1,
        ALL_RED     = 3'd2,
        ROAD_GREEN  = 3'd3,
        ROAD_YELLOW = 3'd4
    } state_t;

    localparam logic [1:0] c_red    = 2'b00;
    localparam logic [1:0] c_green  = 2'b01;
    localparam logic [1:0] c_yellow = 2'b10;

    // A timed state exits on the edge where its counter reaches DELAY-1.
    localparam logic [3:0] c_y2r_last  = 4'(Y2R_DELAY - 1);
    localparam logic [3:0] c_r2g_last  = 4'(R2G_DELAY - 1);
    localparam logic [7:0] c_road_last = 8'(ROAD_MAX_GREEN - 1);

    state_t     state;
    logic [3:0] r_delay_cnt;

`ifdef TLC_ROAD_TIMEOUT_EN
    logic [7:0] r_road_cnt;
`else
    // The road-green limit has no effect in this build.
    logic       w_unused_road_last;
    assign w_unused_road_last = ^c_road_last;
`endif

    // ------------------------------------------------------------------------
    // State and counters. Counters default to zero every cycle and only
    // advance while the FSM stays in their state, so any state change
    // (including illegal-code recovery) leaves them cleared.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= HWY_GREEN;
            r_delay_cnt <= 4'd0;
`ifdef TLC_ROAD_TIMEOUT_EN
            r_road_cnt  <= 8'd0;
`endif
        end else begin
            r_delay_cnt <= 4'd0;
`ifdef TLC_ROAD_TIMEOUT_EN
            r_road_cnt  <= 8'd0;
`endif
            case (state)
                HWY_GREEN: begin
                    if (x) begin
                        state <= HWY_YELLOW;
                    end
                end
                HWY_YELLOW: begin
                    if (r_delay_cnt == c_y2r_last) begin
                        state <= ALL_RED;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + 4'd1;
                    end
                end
                ALL_RED: begin
                    if (r_delay_cnt == c_r2g_last) begin
                        state <= ROAD_GREEN;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + 4'd1;
                    end
                end
                ROAD_GREEN: begin
`ifdef TLC_ROAD_TIMEOUT_EN
                    if (!x || (r_road_cnt == c_road_last)) begin
                        state <= ROAD_YELLOW;
                    end else begin
                        r_road_cnt <= r_road_cnt + 8'd1;
                    end
`else
                    if (!x) begin
                        state <= ROAD_YELLOW;
                    end
`endif
                end
                ROAD_YELLOW: begin
                    if (r_delay_cnt == c_y2r_last) begin
                        state <= HWY_GREEN;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= HWY_GREEN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Lamp decode, straight from the state register so lamps change in the
    // same cycle as the state. Illegal codes show all-red until recovery.
    // ------------------------------------------------------------------------
    always_comb begin
        hwy  = c_red;
        road = c_red;
        case (state)
            HWY_GREEN:   hwy  = c_green;
            HWY_YELLOW:  hwy  = c_yellow;
            ROAD_GREEN:  road = c_green;
            ROAD_YELLOW: road = c_yellow;
            default: begin
                hwy  = c_red;
                road = c_red;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_controller
// Purpose  : Directed self-checking bench for traffic_light_controller.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_controller;

    localparam logic [2:0] c_hg = 3'd0;
    localparam logic [2:0] c_hy = 3'd1;
    localparam logic [2:0] c_ar = 3'd2;
    localparam logic [2:0] c_rg = 3'd3;
    localparam logic [2:0] c_ry = 3'd4;

    localparam logic [1:0] c_red    = 2'b00;
    localparam logic [1:0] c_green  = 2'b01;
    localparam logic [1:0] c_yellow = 2'b10;

    logic       clock;
    logic       clear;
    logic       x;
    logic [1:0] hwy;
    logic [1:0] road;

    int n_cmp;
    int n_fail;

    traffic_light_controller #(
        .Y2R_DELAY      (3),
        .R2G_DELAY      (2),
        .ROAD_MAX_GREEN (8)
    ) dut (
        .clock (clock),
        .clear (clear),
        .x     (x),
        .hwy   (hwy),
        .road  (road)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Check state, both lamps and the safety invariant.
    task automatic chk(input string tag, input logic [2:0] st,
                       input logic [1:0] h, input logic [1:0] r);
        logic [2:0] obs_st;
        logic       safe;
        obs_st = dut.state;
        safe   = !((hwy != c_red) && (road != c_red)) &&
                 (hwy !== 2'b11) && (road !== 2'b11);
        n_cmp++;
        assert (obs_st === st) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, obs_st, st);
        end
        n_cmp++;
        assert (hwy === h) else begin
            n_fail++;
            $error("FAIL %s hwy: observed %b expected %b", tag, hwy, h);
        end
        n_cmp++;
        assert (road === r) else begin
            n_fail++;
            $error("FAIL %s road: observed %b expected %b", tag, road, r);
        end
        n_cmp++;
        assert (safe === 1'b1) else begin
            n_fail++;
            $error("FAIL %s invariant: observed hwy=%b road=%b expected one RED",
                   tag, hwy, road);
        end
    endtask

    // Drive x, let one rising edge pass, return at the falling edge.
    task automatic cyc(input logic xv);
        x = xv;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear  = 1'b1;
        x      = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(negedge clock);
        chk("reset", c_hg, c_green, c_red);
        clear = 1'b0;

        // Idle highway.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0);
            chk("idle", c_hg, c_green, c_red);
        end

        // Full request with x held.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            chk("full_hy", c_hy, c_yellow, c_red);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1);
            chk("full_ar", c_ar, c_red, c_red);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            chk("full_rg", c_rg, c_red, c_green);
        end

        // Car leaves.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            chk("leave_ry", c_ry, c_red, c_yellow);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            chk("leave_hg", c_hg, c_green, c_red);
        end

        // Quick car: x drops during ALL_RED, sequence still completes.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            chk("quick_hy", c_hy, c_yellow, c_red);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1);
            chk("quick_ar", c_ar, c_red, c_red);
        end
        cyc(1'b0);
        chk("quick_rg", c_rg, c_red, c_green);
        cyc(1'b0);
        chk("quick_ry0", c_ry, c_red, c_yellow);
        cyc(1'b0);
        chk("quick_ry1", c_ry, c_red, c_yellow);
        // x ignored in ROAD_YELLOW, then re-requests from HWY_GREEN.
        cyc(1'b1);
        chk("quick_ry2", c_ry, c_red, c_yellow);
        cyc(1'b1);
        chk("quick_hg", c_hg, c_green, c_red);
        cyc(1'b1);
        chk("rearm_hy", c_hy, c_yellow, c_red);
        cyc(1'b1);
        chk("rearm_hy", c_hy, c_yellow, c_red);
        cyc(1'b1);
        chk("rearm_hy", c_hy, c_yellow, c_red);
        cyc(1'b1);
        chk("rearm_ar", c_ar, c_red, c_red);

        // Asynchronous reset mid-ALL_RED, seen before the next rising edge.
        #2 clear = 1'b1;
        #1 chk("async_reset", c_hg, c_green, c_red);
        cyc(1'b1);
        chk("reset_hold", c_hg, c_green, c_red);
        clear = 1'b0;

        // Fresh request after reset: counter must start from zero.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            chk("post_hy", c_hy, c_yellow, c_red);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1);
            chk("post_ar", c_ar, c_red, c_red);
        end

`ifdef TLC_ROAD_TIMEOUT_EN
        // Road green limited to 8 cycles even with x held.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1);
            chk("tmo_rg", c_rg, c_red, c_green);
        end
        cyc(1'b1);
        chk("tmo_ry", c_ry, c_red, c_yellow);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0);
            chk("tmo_ry", c_ry, c_red, c_yellow);
        end
`else
        // Road green holds indefinitely while x stays 1.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1);
            chk("hold_rg", c_rg, c_red, c_green);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            chk("hold_ry", c_ry, c_red, c_yellow);
        end
`endif
        cyc(1'b0);
        chk("final_hg", c_hg, c_green, c_red);
        cyc(1'b0);
        chk("final_idle", c_hg, c_green, c_red);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
- Moore FSM controlling a highway/country-road intersection. Highway is green by default.
- A car sensor on the side road (x) requests right-of-way. The FSM then sequences highway yellow, all-red, road green, and road yellow before returning to highway green.
- Top-level leaf block driving two 2-bit lamp codes; no handshake with other blocks.

Parameters:
- Y2R_DELAY, 3, clock cycles spent in each yellow state (HWY_YELLOW, ROAD_YELLOW); legal range 1..15.
- R2G_DELAY, 2, clock cycles spent in ALL_RED before road green; legal range 1..15.
- ROAD_MAX_GREEN, 8, road-green cycle limit; used only with the optional feature; legal range 1..255.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- x      in  1  side-road car sensor; 1 = car waiting or present. Synchronous to clock.
- hwy    out 2  highway lamp: 2'b00 RED, 2'b01 GREEN, 2'b10 YELLOW; 2'b11 never driven.
- road   out 2  road lamp, same encoding as hwy.

Behaviour:
- State register is named `state`, 3 bits wide: HWY_GREEN=0, HWY_YELLOW=1, ALL_RED=2, ROAD_GREEN=3, ROAD_YELLOW=4. Codes 5..7 are illegal and recover to HWY_GREEN on the next edge.
- Reset: clear=1 forces state=HWY_GREEN and delay counter=0 immediately, independent of clock. Outputs follow at once: hwy=GREEN, road=RED. Reset asserted mid-sequence aborts the sequence with no yellow phase.
- Outputs are pure combinational decode of `state`, zero-latency with respect to the state change:
  - HWY_GREEN: hwy GREEN, road RED.
  - HWY_YELLOW: hwy YELLOW, road RED.
  - ALL_RED: hwy RED, road RED.
  - ROAD_GREEN: hwy RED, road GREEN.
  - ROAD_YELLOW: hwy RED, road YELLOW.
- Transitions are evaluated on the rising clock edge when clear=0:
  - HWY_GREEN: x=1 -> HWY_YELLOW; else stay. No minimum highway-green time.
  - HWY_YELLOW: stays exactly Y2R_DELAY cycles, then -> ALL_RED. x is ignored; the request is committed.
  - ALL_RED: stays exactly R2G_DELAY cycles, then -> ROAD_GREEN. x is ignored.
  - ROAD_GREEN: x=1 -> stay; x=0 -> ROAD_YELLOW. This applies even on the first ROAD_GREEN cycle, so minimum road green is 1 cycle.
  - ROAD_YELLOW: stays exactly Y2R_DELAY cycles, then -> HWY_GREEN. x is ignored. If x=1 on arrival in HWY_GREEN, HWY_YELLOW follows on the next edge.
- Delay counter:
  - 4 bits, cleared on every state change.
  - Increments each cycle in the timed states.
  - The timed state exits on the edge where counter == DELAY-1.
- Safety invariant: hwy and road are never both non-RED in the same cycle.

Optional Feature:
- Macro: TLC_ROAD_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in ROAD_GREEN.
  - After ROAD_MAX_GREEN cycles in ROAD_GREEN, the FSM goes to ROAD_YELLOW even with x=1.
  - Returning to HWY_GREEN with x still 1 restarts the request normally on the next edge.
  - The counter is cleared by reset and on leaving ROAD_GREEN.
- Not defined: the counter logic is absent and ROAD_GREEN holds indefinitely while x=1.

Test Plan:
- Reset: clear=1, x=0 for 2 cycles -> state=0, hwy=01, road=00. Assert clear asynchronously mid-ALL_RED -> state=0 before the next edge.
- Idle: clear=0, x=0 for 4 cycles -> state stays HWY_GREEN, hwy=01, road=00 every cycle.
- Full request: x=1 held 15 cycles, defaults -> HWY_GREEN, then HWY_YELLOW 3 cycles (hwy=10), ALL_RED 2 cycles (00/00), then ROAD_GREEN (hwy=00, road=01) held while x=1.
- Car leaves: drop x=0 while in ROAD_GREEN -> ROAD_YELLOW on next edge for 3 cycles (road=10), then HWY_GREEN. A stays-idle check follows with x=0.
- Quick car: x=1 for 5 cycles then x=0 -> sequence still completes through HWY_YELLOW and ALL_RED. ROAD_GREEN lasts 1 cycle, then ROAD_YELLOW 3 cycles, then HWY_GREEN.
- Invariant and timeout: across all runs assert never (hwy!=00 && road!=00) and never 2'b11. With TLC_ROAD_TIMEOUT_EN and ROAD_MAX_GREEN=8, x=1 held -> ROAD_YELLOW after 8 ROAD_GREEN cycles.
